hazard_detection_unit_multiciclo: RTL

//  Load-use and branch-operand hazard detector for MIPS pipelines with a multi-cycle data memory.

---
 rtl/hazard_detection_unit_multiciclo_if.sv | 37 +++
 rtl/hazard_detection_unit_multiciclo.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_detection_unit_multiciclo_if.sv
// ID-stage hazard detector bundle: ID/EX operand info in, stall request out.
// The master side is the pipeline; the slave side is the detector.
interface hazard_detection_unit_multiciclo_if #(
  parameter int CANT_BITS_ADDR_REGISTROS = 5,
  parameter int CANT_BITS_CONTADOR       = 16
);
  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id;
  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id;
  logic                                i_uses_rs_id;
  logic                                i_uses_rt_id;
  logic                                i_branch_id;
  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_registro_destino_ex;
  logic                                i_read_mem_ex;
  logic                                i_reg_write_ex;
  logic                                i_flush;
  logic                                i_disable_for_exception;
  logic                                i_clear_contador;
  logic                                o_bit_burbuja;
  logic [1:0]                          o_stall_causa;
  logic [CANT_BITS_CONTADOR-1:0]       o_contador_stalls;

  modport master (
    output i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id,
    output i_branch_id, i_registro_destino_ex,
    output i_read_mem_ex, i_reg_write_ex, i_flush,
    output i_disable_for_exception, i_clear_contador,
    input  o_bit_burbuja, o_stall_causa, o_contador_stalls
  );

  modport slave (
    input  i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id,
    input  i_branch_id, i_registro_destino_ex,
    input  i_read_mem_ex, i_reg_write_ex, i_flush,
    input  i_disable_for_exception, i_clear_contador,
    output o_bit_burbuja, o_stall_causa, o_contador_stalls
  );
endinterface

// File: rtl/hazard_detection_unit_multiciclo.sv
// Load-use / branch-operand hazard detector for a MIPS pipeline
// with a multi-cycle data memory, plus a saturating stall counter.
module hazard_detection_unit_multiciclo #(
  parameter int CANT_BITS_ADDR_REGISTROS = 5,
  parameter int LOAD_LATENCIA            = 2,
  parameter int BRANCH_EN_ID             = 1,
  parameter int CANT_BITS_CONTADOR       = 16
) (
  input logic i_clock,
  input logic i_reset,
  hazard_detection_unit_multiciclo_if.slave hdu
);
  localparam int AW = CANT_BITS_ADDR_REGISTROS;
  localparam int L  = LOAD_LATENCIA;
  localparam int CW = CANT_BITS_CONTADOR;

  logic [L:1]    vld_q, vld_d;
  logic [AW-1:0] dst_q [1:L];
  logic [AW-1:0] dst_d [1:L];
  logic [CW-1:0] cnt_q, cnt_d;

  logic [0:L]    v_all;
  logic [AW-1:0] d_all [0:L];
  logic          ld0, lu, bl, alu, br_en;
  logic          burbuja;
  logic [1:0]    causa;

  function automatic logic hit(
    input logic v, input logic [AW-1:0] d
  );
    hit = v & ((hdu.i_uses_rs_id & (hdu.i_rs_id == d))
             | (hdu.i_uses_rt_id & (hdu.i_rt_id == d)));
  endfunction

  // Stage 0 is the instruction currently in EX.
  assign ld0 = hdu.i_read_mem_ex & (|hdu.i_registro_destino_ex);

  always_comb begin
    v_all    = '0;
    v_all[0] = ld0;
    d_all[0] = hdu.i_registro_destino_ex;
    for (int k = 1; k <= L; k++) begin
      v_all[k] = vld_q[k];
      d_all[k] = dst_q[k];
    end
  end

  always_comb begin
    lu = 1'b0;
    bl = 1'b0;
    for (int k = 0; k <= L; k++) begin
      if (hit(v_all[k], d_all[k])) begin
        if (k < L) lu = 1'b1;
        bl = 1'b1;
      end
    end
  end

  assign alu = hdu.i_reg_write_ex & ~hdu.i_read_mem_ex
             & (|hdu.i_registro_destino_ex)
             & hit(1'b1, hdu.i_registro_destino_ex);
  assign br_en = (BRANCH_EN_ID != 0) & hdu.i_branch_id;

  // Reset, flush and exception sequencing mask the request at once.
  always_comb begin
    causa = 2'b00;
    if (!i_reset || hdu.i_flush || hdu.i_disable_for_exception)
      causa = 2'b00;
    else if (lu)
      causa = 2'b01;
    else if (br_en && bl)
      causa = 2'b11;
    else if (br_en && alu)
      causa = 2'b10;
  end

  assign burbuja = (causa != 2'b00);

  always_comb begin
    vld_d    = '0;
    vld_d[1] = ld0 & ~hdu.i_flush;
    dst_d[1] = hdu.i_registro_destino_ex;
    for (int k = 2; k <= L; k++) begin
      vld_d[k] = vld_q[k-1] & ~hdu.i_flush;
      dst_d[k] = dst_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hdu.i_clear_contador)
      cnt_d = '0;
    else if (burbuja && !(&cnt_q))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vld_q <= '0;
      for (int k = 1; k <= L; k++) dst_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 1; k <= L; k++) dst_q[k] <= dst_d[k];
      cnt_q <= cnt_d;
    end
  end

  assign hdu.o_bit_burbuja     = burbuja;
  assign hdu.o_stall_causa     = causa;
  assign hdu.o_contador_stalls = cnt_q;
endmodule
